// File: rtl/bsg_link_token_pkg.sv
// Shared definitions for the DDR link token-return controller:
// FSM state encoding, token timer width and parameter limits.
package bsg_link_token_pkg;

  // Token line FSM states
  typedef enum logic [1:0] {
    TOK_IDLE = 2'd0,
    TOK_HOLD = 2'd1,
    TOK_GAP  = 2'd2
  } tok_state_e;

  // Width of the HOLD/GAP timer
  localparam int TCNT_W = 4;

  // Legal parameter ranges
  localparam int LG_DEC_MIN     = 0;
  localparam int LG_DEC_MAX     = 4;
  localparam int TOKEN_TIME_MIN = 1;
  localparam int TOKEN_TIME_MAX = (1 << TCNT_W) - 1;

  // Timer load value for a phase lasting 'cycles' cycles (timer counts down to 0)
  function automatic logic [TCNT_W-1:0] tcnt_load(input int cycles);
    return TCNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/bsg_link_token_decimator.sv
// Dequeue decimator: counts core dequeues, raises an earn strobe every
// 2^LG_DECIMATION dequeues, and keeps the saturating count of tokens
// earned but not yet started, with a sticky overflow flag.
module bsg_link_token_decimator
  import bsg_link_token_pkg::*;
#(
  parameter int CREDITS       = 64,
  parameter int LG_DECIMATION = 2,
  parameter int PW            = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_link_reset,
  input  logic          i_deq,
  input  logic          i_start,
  output logic          o_earn,
  output logic [PW-1:0] o_pending,
  output logic          o_overflow
);

  localparam int            PMAX   = CREDITS >> LG_DECIMATION;
  localparam logic [PW-1:0] PMAX_V = PW'(PMAX);

  logic          w_earn;
  logic          w_full;
  logic [PW-1:0] r_pending;
  logic          r_overflow;

  if (LG_DECIMATION == 0) begin : g_no_dcnt
    assign w_earn = i_deq;
  end else begin : g_dcnt
    logic [LG_DECIMATION-1:0] r_dcnt;
    // Decimation counter: wraps to 0 on the earning dequeue
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)             r_dcnt <= '0;
      else if (i_link_reset) r_dcnt <= '0;
      else if (i_deq)        r_dcnt <= r_dcnt + LG_DECIMATION'(1);
    end
    assign w_earn = i_deq & (&r_dcnt);
  end

  assign w_full = (r_pending == PMAX_V);

  // Pending tokens: earn and start in the same cycle cancel out
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= '0;
    end else if (i_link_reset) begin
      r_pending <= '0;
    end else if (w_earn && !i_start) begin
      if (!w_full) r_pending <= r_pending + PW'(1);
    end else if (i_start && !w_earn) begin
      r_pending <= r_pending - PW'(1);
    end
  end

  // Sticky overflow: a token earned with nowhere to store it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                             r_overflow <= 1'b0;
    else if (i_link_reset)                 r_overflow <= 1'b0;
    else if (w_earn && !i_start && w_full) r_overflow <= 1'b1;
  end

  assign o_earn     = w_earn;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/bsg_link_token_return_ctrl.sv
// Core-side token return scheduler for the DDR link downstream channel.
// Batches dequeues into credit tokens and drives them on token_o as
// fixed-width (TOKEN_HOLD) pulses separated by at least TOKEN_GAP low cycles.
// deq_i is a plain one-cycle strobe (core yumi): every high cycle is one
// consumed entry, there is no back-pressure on it. enable_i only gates
// the start of a new token; a token in flight always completes.
// Optional feature: define TOKEN_STATS_EN to add the tokens_sent_o counter.
module bsg_link_token_return_ctrl
  import bsg_link_token_pkg::*;
#(
  parameter int CREDITS       = 64,
  parameter int LG_DECIMATION = 2,
  parameter int TOKEN_HOLD    = 2,
  parameter int TOKEN_GAP     = 2,
  localparam int PW = $clog2(CREDITS >> LG_DECIMATION) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          link_reset_i,
  input  logic          deq_i,
  input  logic          enable_i,
  output logic          token_o,
  output logic [PW-1:0] pending_o,
  output logic          busy_o,
  output logic          overflow_o
`ifdef TOKEN_STATS_EN
  ,
  output logic [15:0]   tokens_sent_o
`endif
);

  if (LG_DECIMATION < LG_DEC_MIN || LG_DECIMATION > LG_DEC_MAX) begin : g_bad_lg
    $error("LG_DECIMATION out of range");
  end
  if (TOKEN_HOLD < TOKEN_TIME_MIN || TOKEN_HOLD > TOKEN_TIME_MAX) begin : g_bad_hold
    $error("TOKEN_HOLD out of range");
  end
  if (TOKEN_GAP < TOKEN_TIME_MIN || TOKEN_GAP > TOKEN_TIME_MAX) begin : g_bad_gap
    $error("TOKEN_GAP out of range");
  end
  if ((CREDITS & (CREDITS - 1)) != 0 || CREDITS < (1 << LG_DECIMATION)) begin : g_bad_credits
    $error("CREDITS must be a power of two and at least 2^LG_DECIMATION");
  end

  localparam logic [TCNT_W-1:0] HOLD_LOAD = tcnt_load(TOKEN_HOLD);
  localparam logic [TCNT_W-1:0] GAP_LOAD  = tcnt_load(TOKEN_GAP);

  tok_state_e        r_state;
  tok_state_e        w_state_next;
  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_next;
  logic              r_token;
  logic              w_start;
  logic              w_can_start;
  logic              w_tcnt_zero;
  logic              w_earn;
  logic [PW-1:0]     w_pending;
  logic              w_overflow;

  bsg_link_token_decimator #(
    .CREDITS       (CREDITS),
    .LG_DECIMATION (LG_DECIMATION),
    .PW            (PW)
  ) u_decimator (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_link_reset (link_reset_i),
    .i_deq        (deq_i),
    .i_start      (w_start),
    .o_earn       (w_earn),
    .o_pending    (w_pending),
    .o_overflow   (w_overflow)
  );

  assign w_can_start = enable_i & (w_pending != '0);
  assign w_tcnt_zero = (r_tcnt == '0);

  // Next-state logic; a start from GAP skips IDLE so tokens run back to back
  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = r_tcnt;
    w_start      = 1'b0;
    case (r_state)
      TOK_IDLE: begin
        if (w_can_start) begin
          w_start      = 1'b1;
          w_state_next = TOK_HOLD;
          w_tcnt_next  = HOLD_LOAD;
        end
      end
      TOK_HOLD: begin
        if (w_tcnt_zero) begin
          w_state_next = TOK_GAP;
          w_tcnt_next  = GAP_LOAD;
        end else begin
          w_tcnt_next  = r_tcnt - TCNT_W'(1);
        end
      end
      TOK_GAP: begin
        if (w_tcnt_zero) begin
          if (w_can_start) begin
            w_start      = 1'b1;
            w_state_next = TOK_HOLD;
            w_tcnt_next  = HOLD_LOAD;
          end else begin
            w_state_next = TOK_IDLE;
          end
        end else begin
          w_tcnt_next  = r_tcnt - TCNT_W'(1);
        end
      end
      default: begin
        w_state_next = TOK_IDLE;
        w_tcnt_next  = '0;
      end
    endcase
  end

  // State, timer and registered token line; link reset wins over everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= TOK_IDLE;
      r_tcnt  <= '0;
      r_token <= 1'b0;
    end else if (link_reset_i) begin
      r_state <= TOK_IDLE;
      r_tcnt  <= '0;
      r_token <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tcnt  <= w_tcnt_next;
      r_token <= (w_state_next == TOK_HOLD);
    end
  end

`ifdef TOKEN_STATS_EN
  logic [15:0] r_tokens_sent;
  // Wrapping count of token starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_tokens_sent <= '0;
    else if (link_reset_i) r_tokens_sent <= '0;
    else if (w_start)      r_tokens_sent <= r_tokens_sent + 16'd1;
  end
  assign tokens_sent_o = r_tokens_sent;
`endif

  assign token_o    = r_token;
  assign pending_o  = w_pending;
  assign busy_o     = (r_state != TOK_IDLE);
  assign overflow_o = w_overflow;

  logic w_unused;
  assign w_unused = w_earn;

endmodule
